// File: rtl/magnitude_pkg.sv
// Shared types and defaults for the gradient-magnitude datapath.
package magnitude_pkg;

  typedef enum logic {MAG_L2 = 1'b0, MAG_L1 = 1'b1} mag_mode_t;

  localparam int GRAD_W_DEF  = 10;
  localparam int SHIFT_DEF   = 4;
  localparam int PIXEL_W_DEF = 4;
  localparam int L2_STEP_DEF = 3;
  localparam int L1_STEP_DEF = 4;

  // Width of a per-axis magnitude after abs and noise-floor truncation.
  function automatic int calc_aw(input int grad_w, input int shift);
    return grad_w - 1 - shift;
  endfunction

endpackage

// File: rtl/grad_abs_trunc.sv
// Saturating absolute value of one signed gradient, then drop the noise-floor LSBs.
module grad_abs_trunc
  import magnitude_pkg::*;
#(
  parameter int GRAD_W = GRAD_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  localparam int AW    = calc_aw(GRAD_W, SHIFT)
) (
  input  logic signed [GRAD_W-1:0] g_i,
  output logic        [AW-1:0]     m_o
);

  logic signed [GRAD_W-1:0] neg;
  logic        [GRAD_W-2:0] a;

  always_comb begin
    neg = -g_i;
    // The most-negative code has no positive twin; clamp it to the largest magnitude.
    if (g_i[GRAD_W-1] && (g_i[GRAD_W-2:0] == '0)) begin
      a = '1;
    end else if (g_i[GRAD_W-1]) begin
      a = neg[GRAD_W-2:0];
    end else begin
      a = g_i[GRAD_W-2:0];
    end
  end

  assign m_o = a[GRAD_W-2:SHIFT];

endmodule

// File: rtl/magnitude_pipe.sv
// Three-stage gradient-magnitude pipeline (abs/truncate, metric, sum/quantise) with valid/ready.
module magnitude_pipe
  import magnitude_pkg::*;
#(
  parameter int GRAD_W  = GRAD_W_DEF,
  parameter int SHIFT   = SHIFT_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int L2_STEP = L2_STEP_DEF,
  parameter int L1_STEP = L1_STEP_DEF
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [GRAD_W-1:0]  gx,
  input  logic signed [GRAD_W-1:0]  gy,
  input  logic                      mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [PIXEL_W-1:0] pixel
);

  localparam int AW = calc_aw(GRAD_W, SHIFT);
  localparam int SW = 2 * AW + 1;

  function automatic logic [PIXEL_W-1:0] quantise(input logic [SW-1:0] s, input mag_mode_t md);
    logic [SW-1:0] q;
    if (md == MAG_L1) q = s / SW'(L1_STEP);
    else              q = s / SW'(L2_STEP);
    if (q > SW'((1 << PIXEL_W) - 1)) return '1;
    return q[PIXEL_W-1:0];
  endfunction

  logic adv1, adv2, adv3;

  logic                 vld_p0_q, vld_p1_q, vld_p2_q;
  logic [AW-1:0]        mx_d, my_d, mx_p0_q, my_p0_q;
  mag_mode_t            mode_p0_q, mode_p1_q;
  logic [2*AW-1:0]      mx_w, my_w, sx_d, sy_d, sx_p1_q, sy_p1_q;
  logic [PIXEL_W-1:0]   pixel_d, pixel_p2_q;

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    adv3 = !vld_p2_q || out_ready;
    adv2 = !vld_p1_q || adv3;
    adv1 = !vld_p0_q || adv2;
  end

  assign in_ready  = adv1;
  assign out_valid = vld_p2_q;
  assign pixel     = pixel_p2_q;

  grad_abs_trunc #(.GRAD_W(GRAD_W), .SHIFT(SHIFT)) u_abs_x (.g_i(gx), .m_o(mx_d));
  grad_abs_trunc #(.GRAD_W(GRAD_W), .SHIFT(SHIFT)) u_abs_y (.g_i(gy), .m_o(my_d));

  // Stage 1: per-axis magnitudes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_p0_q  <= 1'b0;
      mx_p0_q   <= '0;
      my_p0_q   <= '0;
      mode_p0_q <= MAG_L2;
    end else if (adv1) begin
      vld_p0_q  <= in_valid;
      mx_p0_q   <= mx_d;
      my_p0_q   <= my_d;
      mode_p0_q <= mag_mode_t'(mode);
    end
  end

  always_comb begin
    mx_w = {{AW{1'b0}}, mx_p0_q};
    my_w = {{AW{1'b0}}, my_p0_q};
    if (mode_p0_q == MAG_L2) begin
      sx_d = mx_w * mx_w;
      sy_d = my_w * my_w;
    end else begin
      sx_d = mx_w;
      sy_d = my_w;
    end
  end

  // Stage 2: metric terms
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_p1_q  <= 1'b0;
      sx_p1_q   <= '0;
      sy_p1_q   <= '0;
      mode_p1_q <= MAG_L2;
    end else if (adv2) begin
      vld_p1_q  <= vld_p0_q;
      sx_p1_q   <= sx_d;
      sy_p1_q   <= sy_d;
      mode_p1_q <= mode_p0_q;
    end
  end

  assign pixel_d = quantise({1'b0, sx_p1_q} + {1'b0, sy_p1_q}, mode_p1_q);

  // Stage 3: quantised pixel, registered straight onto the output
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_p2_q   <= 1'b0;
      pixel_p2_q <= '0;
    end else if (adv3) begin
      vld_p2_q   <= vld_p1_q;
      pixel_p2_q <= pixel_d;
    end
  end

endmodule
